// File: rtl/imem_loader.sv
// imem_loader: receives a length-prefixed byte stream and writes it into
// instruction memory as 32-bit little-endian words. The RV32I core is held
// in reset until the whole image has been written.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        LEN_LO = 3'd0,
        LEN_HI = 3'd1,
        DATA   = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4,
        ERR    = 3'd5
    } state_t;

    // Image depth in words, widened so 2^ADDR_W itself is representable.
    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W-1:0] widx_q, widx_d;
    logic [1:0]        bidx_q, bidx_d;
    logic [23:0]       asm_q, asm_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              accept;
    logic [15:0]       n_full;
    logic              last_word;

    // Handshake and status outputs decoded from the current state; reset
    // suppresses acceptance and any write strobe in the same cycle.
    always_comb begin
        rx_ready   = !reset && (state_q == LEN_LO || state_q == LEN_HI || state_q == DATA);
        accept     = rx_valid && rx_ready;
        mem_we     = !reset && (state_q == WRITE);
        core_reset = (state_q != DONE);
        done       = (state_q == DONE);
        err        = (state_q == ERR);
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
    end

    // Next-state logic: length capture, word assembly and write sequencing.
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        widx_d    = widx_q;
        bidx_d    = bidx_q;
        asm_d     = asm_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        n_full    = {rx_data, len_q[7:0]};
        last_word = ((17'(widx_q) + 17'd1) == {1'b0, len_q});

        case (state_q)
            LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = rx_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (accept) begin
                    len_d  = n_full;
                    widx_d = '0;
                    bidx_d = 2'd0;
                    if (n_full == 16'd0) begin
                        state_d = DONE;
                    end else if ({1'b0, n_full} > DEPTH) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    bidx_d = bidx_q + 2'd1;
                    case (bidx_q)
                        2'd0: asm_d[7:0]   = rx_data;
                        2'd1: asm_d[15:8]  = rx_data;
                        2'd2: asm_d[23:16] = rx_data;
                        default: begin
                            // Fourth byte completes the word: present it for one WRITE cycle.
                            addr_d  = widx_q;
                            wdata_d = {rx_data, asm_q};
                            state_d = WRITE;
                        end
                    endcase
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    widx_d  = widx_q + 1'b1;
                    state_d = DATA;
                end
            end
            DONE:    state_d = DONE;
            ERR:     state_d = ERR;
            default: state_d = LEN_LO;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LEN_LO;
            len_q   <= '0;
            widx_q  <= '0;
            bidx_q  <= '0;
            asm_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            widx_q  <= widx_d;
            bidx_q  <= bidx_d;
            asm_q   <= asm_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: table of byte-stream scenarios plus hand-written
// sequences for the full-depth image, mid-load reset and post-DONE traffic.
module tb_imem_loader;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              core_reset;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_reset (core_reset),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Write log captured mid-cycle while the strobe is high.
    logic [ADDR_W-1:0] wr_addr [0:511];
    logic [31:0]       wr_data [0:511];
    int                nw = 0;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (nw < 512) begin
                wr_addr[nw] = mem_addr;
                wr_data[nw] = mem_wdata;
            end
            nw = nw + 1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One byte offered until accepted; in toggle mode one idle edge precedes it.
    task automatic send_byte(input logic [7:0] b, input bit tog);
        int n;
        n = 0;
        if (tog) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", {63'd0, rx_ready}, 64'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h5A;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        rx_valid = 1'b0;
        @(negedge clk);
        chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_core_reset", {63'd0, core_reset}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_mem_addr", {56'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        reset = 1'b0;
    endtask

    typedef struct packed {
        logic [95:0] bytes;    // stream, first byte in bits [7:0]
        logic [7:0]  nb;
        logic        tog;
        logic        we_after; // mem_we in the cycle after the last accepted byte
        logic [7:0]  nwr;
        logic [7:0]  a0;
        logic [31:0] d0;
        logic [7:0]  a1;
        logic [31:0] d1;
        logic        done_e;
        logic        err_e;
    } vec_t;

    vec_t tv [5];

    initial begin
        int base;
        int errs;
        logic [31:0] w;
        logic [95:0] bs;
        logic [31:0] hold_d;
        logic [ADDR_W-1:0] hold_a;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;

        tv[0] = '{96'h0000_00B0_0593_00A0_0513_0002, 8'd10, 1'b0, 1'b1, 8'd2,
                  8'h00, 32'h00A0_0513, 8'h01, 32'h00B0_0593, 1'b1, 1'b0};
        tv[1] = '{96'h0000_00B0_0593_00A0_0513_0002, 8'd10, 1'b1, 1'b1, 8'd2,
                  8'h00, 32'h00A0_0513, 8'h01, 32'h00B0_0593, 1'b1, 1'b0};
        tv[2] = '{96'h0, 8'd2, 1'b0, 1'b0, 8'd0,
                  8'h00, 32'h0, 8'h00, 32'h0, 1'b1, 1'b0};
        tv[3] = '{96'h0101, 8'd2, 1'b0, 1'b0, 8'd0,
                  8'h00, 32'h0, 8'h00, 32'h0, 1'b0, 1'b1};
        tv[4] = '{96'hDEAD_BEEF_0001, 8'd6, 1'b0, 1'b1, 8'd1,
                  8'h00, 32'hDEAD_BEEF, 8'h00, 32'h0, 1'b0 ^ 1'b1, 1'b0};

        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_reset();
            base = nw;
            bs   = tv[i].bytes;
            for (int k = 0; k < int'(tv[i].nb); k++) begin
                send_byte(bs[8*k +: 8], tv[i].tog);
            end
            @(negedge clk);
            chk($sformatf("v%0d_we_latency", i), {63'd0, mem_we}, {63'd0, tv[i].we_after});
            @(negedge clk);
            chk($sformatf("v%0d_done_latency", i), {63'd0, done}, {63'd0, tv[i].done_e});
            chk($sformatf("v%0d_core_rst_latency", i), {63'd0, core_reset}, {63'd0, !tv[i].done_e});
            repeat (4) @(negedge clk);
            chk($sformatf("v%0d_nwrites", i), 64'(nw - base), {56'd0, tv[i].nwr});
            if (tv[i].nwr >= 8'd1 && nw > base) begin
                chk($sformatf("v%0d_addr0", i), {56'd0, wr_addr[base]}, {56'd0, tv[i].a0});
                chk($sformatf("v%0d_data0", i), {32'd0, wr_data[base]}, {32'd0, tv[i].d0});
            end
            if (tv[i].nwr >= 8'd2 && nw > base + 1) begin
                chk($sformatf("v%0d_addr1", i), {56'd0, wr_addr[base+1]}, {56'd0, tv[i].a1});
                chk($sformatf("v%0d_data1", i), {32'd0, wr_data[base+1]}, {32'd0, tv[i].d1});
            end
            chk($sformatf("v%0d_done", i), {63'd0, done}, {63'd0, tv[i].done_e});
            chk($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, tv[i].err_e});
            chk($sformatf("v%0d_core_reset", i), {63'd0, core_reset}, {63'd0, !tv[i].done_e});
            chk($sformatf("v%0d_rx_ready", i), {63'd0, rx_ready}, 64'd0);
            chk($sformatf("v%0d_done_err_excl", i), {63'd0, done & err}, 64'd0);
        end

        // Full-depth image: N = 256, word i = 0x1000_0000 + i.
        do_reset();
        base = nw;
        send_byte(8'h00, 1'b0);
        send_byte(8'h01, 1'b0);
        for (int i = 0; i < 256; i++) begin
            w = 32'h1000_0000 + 32'(i);
            for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b0);
        end
        @(negedge clk);
        chk("n256_last_we", {63'd0, mem_we}, 64'd1);
        @(negedge clk);
        chk("n256_done", {63'd0, done}, 64'd1);
        chk("n256_err", {63'd0, err}, 64'd0);
        chk("n256_nwrites", 64'(nw - base), 64'd256);
        errs = 0;
        for (int i = 0; i < 256; i++) begin
            if (base + i < 512) begin
                if (wr_addr[base+i] !== ADDR_W'(i)) errs++;
                if (wr_data[base+i] !== 32'h1000_0000 + 32'(i)) errs++;
            end
        end
        chk("n256_seq_errors", 64'(errs), 64'd0);
        if (base + 255 < 512) chk("n256_last_addr", {56'd0, wr_addr[base+255]}, 64'hFF);

        // Reset after two data bytes; the restarted stream must be parsed afresh.
        do_reset();
        base = nw;
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        do_reset();
        chk("midrst_no_write", 64'(nw - base), 64'd0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        repeat (3) @(negedge clk);
        chk("midrst_nwrites", 64'(nw - base), 64'd1);
        if (nw > base) begin
            chk("midrst_addr", {56'd0, wr_addr[base]}, 64'd0);
            chk("midrst_data", {32'd0, wr_data[base]}, 64'hDEAD_BEEF);
        end
        chk("midrst_done", {63'd0, done}, 64'd1);

        // Extra traffic after DONE is refused and changes nothing.
        base   = nw;
        hold_a = mem_addr;
        hold_d = mem_wdata;
        rx_valid = 1'b1;
        rx_data  = 8'hAA;
        repeat (5) @(negedge clk);
        chk("post_done_rx_ready", {63'd0, rx_ready}, 64'd0);
        chk("post_done_mem_we", {63'd0, mem_we}, 64'd0);
        chk("post_done_nwrites", 64'(nw - base), 64'd0);
        chk("post_done_done", {63'd0, done}, 64'd1);
        chk("post_done_core_reset", {63'd0, core_reset}, 64'd0);
        chk("post_done_addr_hold", {56'd0, mem_addr}, {56'd0, hold_a});
        chk("post_done_wdata_hold", {32'd0, mem_wdata}, 64'hDEAD_BEEF);
        chk("post_done_wdata_same", {32'd0, mem_wdata}, {32'd0, hold_d});
        rx_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of instruction memory; depth 2^ADDR_W words.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rx_valid  input  1  upstream byte valid.
REQ-005 rx_data  input  8  upstream byte.
REQ-006 rx_ready  output  1  loader accepts byte; transfer occurs on an edge where rx_valid && rx_ready.
REQ-007 mem_we  output  1  one-cycle instruction-memory write strobe.
REQ-008 mem_addr  output  ADDR_W  word address of write.
REQ-009 mem_wdata  output  32  write data.
REQ-010 core_reset  output  1  active-high reset to the RV32I core; holds core until image loaded.
REQ-011 done  output  1  image load complete.
REQ-012 err  output  1  image length invalid; sticky until reset.

Function
REQ-013 Stream format SHALL be: 2-byte little-endian word count N, then N*4 data bytes, each word little-endian (first byte -> bits[7:0]).
REQ-014 FSM states SHALL be LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR; reset state LEN_LO.
REQ-015 rx_ready SHALL be 1 in LEN_LO, LEN_HI, DATA; 0 in WRITE, DONE, ERR and while reset is high.
REQ-016 LEN_LO -> LEN_HI on byte accept, capturing N[7:0]; LEN_HI -> on byte accept capturing N[15:8].
REQ-017 From LEN_HI: N == 0 -> DONE; N > 2^ADDR_W -> ERR; else -> DATA with word index 0, byte index 0.
REQ-018 DATA SHALL shift each accepted byte into the word assembly register at byte-index position; byte index wraps 3 -> 0.
REQ-019 On acceptance of byte index 3, next state SHALL be WRITE; in WRITE mem_we = 1 for exactly one cycle, mem_addr = word index, mem_wdata = assembled word.
REQ-020 WRITE -> DONE if word index == N-1, else -> DATA with word index incremented; no gap beyond the single WRITE cycle.
REQ-021 Latency: 4th byte accepted at edge t -> mem_we high between edges t and t+1; write commits at edge t+1.
REQ-022 In DONE: core_reset = 0, done = 1, mem_we = 0; held until reset. Extra upstream bytes are not accepted.
REQ-023 In ERR: err = 1, core_reset = 1, done = 0, mem_we = 0; held until reset.
REQ-024 core_reset SHALL be 1 in every state except DONE; done and err SHALL never both be 1.
REQ-025 rx_valid low stalls FSM in current state with no output change; rx_data ignored when not accepted.
REQ-026 mem_we SHALL never assert outside WRITE; mem_addr and mem_wdata hold their last values when mem_we = 0.
REQ-027 N == 2^ADDR_W SHALL be legal; final write address 2^ADDR_W-1, no wrap.

Reset
REQ-028 reset high at an edge SHALL force state LEN_LO, word/byte indices 0, mem_we 0, mem_addr 0, mem_wdata 0, core_reset 1, done 0, err 0.
REQ-029 Reset mid-load SHALL discard partial word and count; no write is issued on the reset edge; the next byte accepted after reset is N[7:0].

Verification
REQ-030 Bytes 02 00 13 05 A0 00 93 05 B0 00, rx_valid always 1 -> writes addr0=0x00A00513, addr1=0x00B00593; core_reset falls and done rises at the edge after the 2nd write.
REQ-031 Same stream with rx_valid toggled 1/0 each cycle -> identical writes, exactly 2 mem_we pulses, no duplicate or dropped bytes.
REQ-032 Bytes 00 00 -> DONE immediately after LEN_HI, zero mem_we pulses, core_reset 0.
REQ-033 ADDR_W=8, bytes 01 01 (N=257) -> err = 1, core_reset stays 1, rx_ready 0, zero writes; N=256 with full payload -> last write addr 0xFF, done = 1.
REQ-034 reset pulsed after 2 of 4 data bytes, then full stream 01 00 EF BE AD DE -> single write addr0=0xDEADBEEF, done = 1.
REQ-035 After DONE, further rx_valid bytes -> rx_ready 0, no mem_we, outputs unchanged.
